// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store requester for the single-port 8-bit data memory.
// Define LSU_WORD_ACCESS_EN for 16-bit little-endian two-beat accesses.
module dmem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, ACC0, ACC1, RWAIT, RSP
  } state_t;

  state_t state, state_n;

  logic       word_in;
  logic [7:0] hi_in;

`ifdef LSU_WORD_ACCESS_EN
  assign word_in = req_word;
  assign hi_in   = req_wdata[15:8];
`else
  logic unused_word;
  assign word_in     = 1'b0;
  assign hi_in       = 8'h00;
  assign unused_word = ^{req_word, req_wdata[15:8]};
`endif

  logic        write_q, write_n;
  logic        word_q, word_n;
  logic [7:0]  addr_q, addr_n;
  logic [7:0]  hi_q, hi_n;
  logic [7:0]  lo_q, lo_n;
  logic        mem_we_n;
  logic [7:0]  mem_addr_n;
  logic [7:0]  mem_wdata_n;
  logic        rsp_valid_n;
  logic [15:0] rsp_data_n;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n     = state;
    write_n     = write_q;
    word_n      = word_q;
    addr_n      = addr_q;
    hi_n        = hi_q;
    lo_n        = lo_q;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_n    = ACC0;
          write_n    = req_write;
          word_n     = word_in;
          addr_n     = req_addr;
          hi_n       = hi_in;
          mem_we_n   = req_write;
          mem_addr_n = req_addr;
          if (req_write) mem_wdata_n = req_wdata[7:0];
        end
      end
      ACC0: begin
        if (word_q) begin
          state_n    = ACC1;
          mem_we_n   = write_q;
          mem_addr_n = addr_q + 8'd1;
          if (write_q) mem_wdata_n = hi_q;
        end else begin
          state_n = write_q ? IDLE : RWAIT;
        end
      end
      ACC1: begin
        // Low byte of a word load arrives while the high address is out.
        if (write_q) begin
          state_n = IDLE;
        end else begin
          lo_n    = mem_rdata;
          state_n = RWAIT;
        end
      end
      RWAIT: begin
        rsp_data_n  = word_q ? {mem_rdata, lo_q}
                             : {8'h00, mem_rdata};
        rsp_valid_n = 1'b1;
        state_n     = RSP;
      end
      RSP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= 8'h00;
      hi_q      <= 8'h00;
      lo_q      <= 8'h00;
      mem_we    <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
    end else begin
      state     <= state_n;
      write_q   <= write_n;
      word_q    <= word_n;
      addr_q    <= addr_n;
      hi_q      <= hi_n;
      lo_q      <= lo_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
    end
  end

endmodule
